// File: rtl/dds_onchip_ram_dp.sv
// Dual-port Avalon-MM on-chip RAM with byte lanes, configurable read latency,
// sticky out-of-range flags and a saturating write-write collision counter.
module dds_onchip_ram_dp #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 6000,
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned COLL_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  reset_req,
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_oor,
    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_oor,
    output logic [COLL_W-1:0]     coll_count
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CMP_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ce;
    logic              rd1, rd2, wr1, wr2, inr1, inr2, same_addr, coll;
    logic [BE_W-1:0]   we1, we2;
    logic [1:0]        rd_v, wr_v, inr_v;

    logic [1:0]             v0_q, v0_d, oor0_q, oor0_d, v1_q, v1_d;
    logic [1:0]             rvalid_q, rvalid_d, oor_q, oor_d;
    logic [1:0][DATA_W-1:0] d1_q, d1_d, rdata_q, rdata_d, ram_dout;
    logic [COLL_W-1:0]      coll_q, coll_d;
    logic [DATA_W-1:0]      s0_data, fin_d;
    logic                   fin_v;

    // Request decode and per-lane write enables; s1 owns overlapping lanes.
    always_comb begin : decode
        ce        = clken & ~reset_req;
        inr1      = {1'b0, s1_address} < CMP_W'(DEPTH);
        inr2      = {1'b0, s2_address} < CMP_W'(DEPTH);
        rd1       = s1_chipselect & s1_read & ~s1_write;
        rd2       = s2_chipselect & s2_read & ~s2_write;
        wr1       = s1_chipselect & s1_write;
        wr2       = s2_chipselect & s2_write;
        same_addr = (s1_address == s2_address);
        we1       = (ce && wr1 && inr1) ? s1_byteenable : BE_W'(0);
        we2       = (ce && wr2 && inr2) ? s2_byteenable : BE_W'(0);
        if (same_addr) begin
            we2 = we2 & ~we1;
        end
        coll  = ce & wr1 & wr2 & inr1 & inr2 & same_addr & (|(s1_byteenable & s2_byteenable));
        rd_v  = {rd2, rd1};
        wr_v  = {wr2, wr1};
        inr_v = {inr2, inr1};
    end

    // Block-RAM array: no reset, synchronous read gives old data on a cross-port write.
    always_ff @(posedge clk) begin : ram_port
        for (int i = 0; i < BE_W; i++) begin
            if (we1[i]) begin
                mem[s1_address][8*i +: 8] <= s1_writedata[8*i +: 8];
            end
            if (we2[i]) begin
                mem[s2_address][8*i +: 8] <= s2_writedata[8*i +: 8];
            end
        end
        if (ce && rd1 && inr1) begin
            ram_dout[0] <= mem[s1_address];
        end
        if (ce && rd2 && inr2) begin
            ram_dout[1] <= mem[s2_address];
        end
    end

    always_comb begin : next_state
        v0_d     = v0_q;
        oor0_d   = oor0_q;
        v1_d     = v1_q;
        d1_d     = d1_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        oor_d    = oor_q;
        coll_d   = coll_q;
        s0_data  = '0;
        fin_v    = 1'b0;
        fin_d    = '0;
        if (ce) begin
            for (int p = 0; p < 2; p++) begin
                s0_data   = oor0_q[p] ? DATA_W'(0) : ram_dout[p];
                v0_d[p]   = rd_v[p];
                oor0_d[p] = ~inr_v[p];
                v1_d[p]   = v0_q[p];
                if (v0_q[p]) begin
                    d1_d[p] = s0_data;
                end
                if (READ_LATENCY == 2) begin
                    fin_v = v1_q[p];
                    fin_d = d1_q[p];
                end else begin
                    fin_v = v0_q[p];
                    fin_d = s0_data;
                end
                rvalid_d[p] = fin_v;
                if (fin_v) begin
                    rdata_d[p] = fin_d;
                end
                if ((rd_v[p] | wr_v[p]) & ~inr_v[p]) begin
                    oor_d[p] = 1'b1;
                end
            end
            if (coll && (coll_q != {COLL_W{1'b1}})) begin
                coll_d = coll_q + COLL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            v0_q     <= '0;
            oor0_q   <= '0;
            v1_q     <= '0;
            d1_q     <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            oor_q    <= '0;
            coll_q   <= '0;
        end else begin
            v0_q     <= v0_d;
            oor0_q   <= oor0_d;
            v1_q     <= v1_d;
            d1_q     <= d1_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            oor_q    <= oor_d;
            coll_q   <= coll_d;
        end
    end

    assign s1_readdata      = rdata_q[0];
    assign s1_readdatavalid = rvalid_q[0];
    assign s1_oor           = oor_q[0];
    assign s2_readdata      = rdata_q[1];
    assign s2_readdatavalid = rvalid_q[1];
    assign s2_oor           = oor_q[1];
    assign coll_count       = coll_q;

endmodule

// File: tb/tb_dds_onchip_ram_dp.sv
// Directed bench: two instances (read latency 1 and 2) share one stimulus stream.
module tb_dds_onchip_ram_dp;

    logic        clk;
    logic        reset, clken, reset_req;
    logic [12:0] s1_address, s2_address;
    logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;

    logic [31:0] l1_s1_rd, l1_s2_rd, l2_s1_rd, l2_s2_rd;
    logic        l1_s1_v, l1_s2_v, l2_s1_v, l2_s2_v;
    logic        l1_s1_oor, l1_s2_oor, l2_s1_oor, l2_s2_oor;
    logic [7:0]  l1_coll, l2_coll;

    int n_checks = 0;
    int n_fail   = 0;

    dds_onchip_ram_dp #(.READ_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(l1_s1_rd), .s1_readdatavalid(l1_s1_v), .s1_oor(l1_s1_oor),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(l1_s2_rd), .s2_readdatavalid(l1_s2_v), .s2_oor(l1_s2_oor),
        .coll_count(l1_coll)
    );

    dds_onchip_ram_dp #(.READ_LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(l2_s1_rd), .s1_readdatavalid(l2_s1_v), .s1_oor(l2_s1_oor),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(l2_s2_rd), .s2_readdatavalid(l2_s2_v), .s2_oor(l2_s2_oor),
        .coll_count(l2_coll)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          port;
        bit          is_wr;
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0; s1_byteenable = 4'h0;
        s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0; s2_byteenable = 4'h0;
    endtask

    task automatic drive(input bit p, input bit rd, input bit wr, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        if (!p) begin
            s1_address = a; s1_chipselect = 1'b1; s1_read = rd; s1_write = wr;
            s1_byteenable = be; s1_writedata = d;
        end else begin
            s2_address = a; s2_chipselect = 1'b1; s2_read = rd; s2_write = wr;
            s2_byteenable = be; s2_writedata = d;
        end
    endtask

    task automatic do_write(input bit p, input logic [12:0] a, input logic [3:0] be,
                            input logic [31:0] d);
        drive(p, 1'b0, 1'b1, a, be, d);
        @(negedge clk);
        idle();
    endtask

    // Called at the negedge after the accepting edge.
    task automatic expect_read(input bit p, input logic [31:0] exp, input string nm);
        @(negedge clk);
        check({nm, "_l1_valid"}, 32'(p ? l1_s2_v : l1_s1_v), 32'd1);
        check({nm, "_l1_data"}, p ? l1_s2_rd : l1_s1_rd, exp);
        check({nm, "_l2_early"}, 32'(p ? l2_s2_v : l2_s1_v), 32'd0);
        @(negedge clk);
        check({nm, "_l2_valid"}, 32'(p ? l2_s2_v : l2_s1_v), 32'd1);
        check({nm, "_l2_data"}, p ? l2_s2_rd : l2_s1_rd, exp);
        check({nm, "_l1_pulse"}, 32'(p ? l1_s2_v : l1_s1_v), 32'd0);
        check({nm, "_l1_hold"}, p ? l1_s2_rd : l1_s1_rd, exp);
    endtask

    task automatic read_check(input bit p, input logic [12:0] a, input logic [31:0] exp,
                              input string nm);
        drive(p, 1'b1, 1'b0, a, 4'h0, 32'h0);
        @(negedge clk);
        idle();
        expect_read(p, exp, nm);
    endtask

    logic [31:0] got1 [8];
    logic [31:0] got2 [8];
    logic [31:0] b2b_exp [3];
    int          n1, n2;

    initial begin
        vecs[0]  = '{0, 1, 13'd5,    4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{0, 0, 13'd5,    4'h0, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{0, 1, 13'd7,    4'hF, 32'h11223344, 32'h0};
        vecs[3]  = '{1, 1, 13'd7,    4'h5, 32'hAABBCCDD, 32'h0};
        vecs[4]  = '{0, 0, 13'd7,    4'h0, 32'h0,        32'h11BB33DD};
        vecs[5]  = '{1, 0, 13'd7,    4'h0, 32'h0,        32'h11BB33DD};
        vecs[6]  = '{1, 1, 13'd8,    4'hF, 32'h12345678, 32'h0};
        vecs[7]  = '{0, 1, 13'd8,    4'h0, 32'hFFFFFFFF, 32'h0};
        vecs[8]  = '{1, 0, 13'd8,    4'h0, 32'h0,        32'h12345678};
        vecs[9]  = '{1, 1, 13'd5999, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[10] = '{0, 0, 13'd5999, 4'h0, 32'h0,        32'hCAFEF00D};
        vecs[11] = '{0, 1, 13'd5,    4'h8, 32'h77000000, 32'h0};
        vecs[12] = '{1, 0, 13'd5,    4'h0, 32'h0,        32'h77ADBEEF};
        vecs[13] = '{0, 1, 13'd10,   4'hF, 32'h00000055, 32'h0};
        vecs[14] = '{1, 1, 13'd20,   4'hF, 32'hFEEDF00D, 32'h0};
        vecs[15] = '{0, 0, 13'd20,   4'h0, 32'h0,        32'hFEEDF00D};

        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        s1_address = '0; s2_address = '0; s1_writedata = '0; s2_writedata = '0;
        idle();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_rdata", l1_s1_rd | l1_s2_rd | l2_s1_rd | l2_s2_rd, 32'h0);
        check("rst_valid", 32'({l1_s1_v, l1_s2_v, l2_s1_v, l2_s2_v}), 32'h0);
        check("rst_oor", 32'({l1_s1_oor, l1_s2_oor, l2_s1_oor, l2_s2_oor}), 32'h0);
        check("rst_coll", 32'(l1_coll | l2_coll), 32'h0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].port, vecs[i].addr, vecs[i].be, vecs[i].data);
            end else begin
                read_check(vecs[i].port, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
            end
        end

        // Write-write collision: s1 wins lane 0, s2 fills the rest.
        drive(0, 1'b0, 1'b1, 13'd9, 4'h1, 32'h000000FF);
        drive(1, 1'b0, 1'b1, 13'd9, 4'hF, 32'hFFFFFF00);
        @(negedge clk);
        idle();
        check("coll1_l1", 32'(l1_coll), 32'd1);
        check("coll1_l2", 32'(l2_coll), 32'd1);
        read_check(0, 13'd9, 32'hFFFFFFFF, "coll_data");

        // Different addresses, and disjoint lanes on one address: no collision.
        drive(0, 1'b0, 1'b1, 13'd11, 4'hF, 32'h0);
        drive(1, 1'b0, 1'b1, 13'd12, 4'hF, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 13'd13, 4'h3, 32'h00001111);
        drive(1, 1'b0, 1'b1, 13'd13, 4'hC, 32'h22220000);
        @(negedge clk);
        idle();
        check("nocoll_l1", 32'(l1_coll), 32'd1);
        read_check(1, 13'd13, 32'h22221111, "disjoint");

        for (int i = 0; i < 299; i++) begin
            drive(0, 1'b0, 1'b1, 13'd9, 4'h1, 32'h000000AA);
            drive(1, 1'b0, 1'b1, 13'd9, 4'hF, 32'h000000BB);
            @(negedge clk);
        end
        idle();
        check("coll_sat_l1", 32'(l1_coll), 32'd255);
        check("coll_sat_l2", 32'(l2_coll), 32'd255);
        read_check(1, 13'd9, 32'h000000AA, "s1_wins");

        // Cross-port read-during-write returns the old word.
        drive(0, 1'b1, 1'b0, 13'd10, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b1, 13'd10, 4'hF, 32'h00000066);
        @(negedge clk);
        idle();
        expect_read(0, 32'h00000055, "rdw_old");
        read_check(0, 13'd10, 32'h00000066, "rdw_new");

        // Out-of-range access on s2.
        read_check(1, 13'd6000, 32'h0, "oor_rd");
        check("oor_s2_l1", 32'(l1_s2_oor), 32'd1);
        check("oor_s2_l2", 32'(l2_s2_oor), 32'd1);
        check("oor_s1_clear", 32'(l1_s1_oor | l2_s1_oor), 32'd0);
        do_write(1, 13'd6000, 4'hF, 32'hBAD0BAD0);
        read_check(1, 13'd5999, 32'hCAFEF00D, "oor_wr_last");
        read_check(1, 13'd5, 32'h77ADBEEF, "oor_wr_5");
        check("oor_sticky", 32'(l1_s2_oor & l2_s2_oor), 32'd1);

        // Back-to-back reads with reset_req during the second one.
        for (int i = 0; i < 4; i++) begin
            do_write(0, 13'(i), 4'hF, 32'hC0DE0000 + 32'(i));
        end
        b2b_exp[0] = 32'hC0DE0000; b2b_exp[1] = 32'hC0DE0002; b2b_exp[2] = 32'hC0DE0003;
        n1 = 0; n2 = 0;
        for (int k = 0; k < 10; k++) begin
            if (l1_s1_v && n1 < 8) begin got1[n1] = l1_s1_rd; n1++; end
            if (l2_s1_v && n2 < 8) begin got2[n2] = l2_s1_rd; n2++; end
            if (k < 4) drive(0, 1'b1, 1'b0, 13'(k), 4'h0, 32'h0);
            else idle();
            reset_req = (k == 1);
            @(negedge clk);
        end
        reset_req = 1'b0;
        check("b2b_cnt_l1", 32'(n1), 32'd3);
        check("b2b_cnt_l2", 32'(n2), 32'd3);
        for (int j = 0; j < 3; j++) begin
            if (j < n1) check($sformatf("b2b_l1_%0d", j), got1[j], b2b_exp[j]);
            if (j < n2) check($sformatf("b2b_l2_%0d", j), got2[j], b2b_exp[j]);
        end

        // Reset right after a read is accepted discards the pulse.
        drive(0, 1'b1, 1'b0, 13'd20, 4'h0, 32'h0);
        @(negedge clk);
        idle();
        reset = 1'b1;
        n1 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            reset = 1'b0;
            if (l1_s1_v || l2_s1_v) n1++;
        end
        check("rst_flush", 32'(n1), 32'd0);
        check("rst2_coll", 32'(l1_coll | l2_coll), 32'd0);
        check("rst2_oor", 32'(l1_s2_oor | l2_s2_oor), 32'd0);
        check("rst2_rdata", l1_s1_rd | l2_s1_rd, 32'h0);
        read_check(0, 13'd20, 32'hFEEDF00D, "post_rst");
        read_check(1, 13'd13, 32'h22221111, "post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_onchip_ram_dp.md
Name: dds_onchip_ram_dp

Overview:
- Parametrised dual-port Avalon-MM on-chip RAM for the Nios II subsystem. Successor to the fixed 32-bit, 6000-word single-port RAM.
- Two independent slaves (s1, s2) share one memory array. Typical use: s1 on the CPU data master, s2 on the DDS waveform/DMA master.
- Adds configurable width, depth and read latency, a readdatavalid pipeline, out-of-range detection and a write-collision counter.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 6000, number of words; need not be a power of two.
- ADDR_W, 13, word-address width; must satisfy 2^ADDR_W >= DEPTH.
- READ_LATENCY, 1, read latency in cycles; legal values are 1 and 2 (2 adds an output register).
- COLL_W, 8, width of the collision counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clken  in  1  global clock enable
- reset_req  in  1  reset-request hold; freezes the array and pipelines while high
- s1_address  in  ADDR_W  port-1 word address
- s1_chipselect  in  1  port-1 select
- s1_read  in  1  port-1 read strobe
- s1_write  in  1  port-1 write strobe
- s1_byteenable  in  DATA_W/8  port-1 byte lanes
- s1_writedata  in  DATA_W  port-1 write data
- s1_readdata  out  DATA_W  port-1 read data
- s1_readdatavalid  out  1  port-1 read data valid
- s1_oor  out  1  port-1 sticky out-of-range flag
- s2_* (address, chipselect, read, write, byteenable, writedata, readdata, readdatavalid, oor): identical to s1_*
- coll_count  out  COLL_W  saturating count of write-write collisions

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset sets sN_readdata=0, sN_readdatavalid=0, sN_oor=0, coll_count=0 and flushes all valid pipelines. Memory contents are not cleared by reset.
- ce = clken & ~reset_req. When ce=0:
  - no array writes occur;
  - pipelines, flags and counter hold their values;
  - accepted requests are dropped, not queued.
- Reset overrides ce.
- Request decode per port:
  - rd = chipselect & read & ~write
  - wr = chipselect & write
  - If read and write are both high, the write is performed and no readdatavalid is produced.
- Read timing (accepted at edge T):
  - READ_LATENCY=1: readdata and readdatavalid=1 present after edge T+1.
  - READ_LATENCY=2: present after edge T+2.
  - readdatavalid is a one-cycle pulse per read.
  - Back-to-back reads give back-to-back valid pulses; no waitrequest, full throughput.
  - readdata holds its last value while readdatavalid=0.
- Writes: only lanes with byteenable[i]=1 update bits [8i+7:8i]. A write with byteenable all zero is a no-op and is not counted as a collision.
- Out of range (address >= DEPTH):
  - the write is dropped;
  - the read returns 0 with normal latency and a valid pulse;
  - sN_oor sets and stays set until reset.
- Read-during-write:
  - Same port: a write and read cannot both be issued, so no conflict arises.
  - Cross port, same address, same cycle: the read returns the old data.
- Write-write collision (both ports write the same in-range address with overlapping nonzero byteenables in one cycle):
  - s1 wins on the overlapping lanes;
  - non-overlapping lanes from both ports are written;
  - coll_count increments and saturates at 2^COLL_W-1.
- Reset mid-operation: in-flight valid pulses are discarded. The first read accepted after reset deasserts returns with normal latency.
- The array must infer vendor block RAM: no reset on the array, and the read path uses the registered address.

Test Plan:
- Reset, s1 write 0xDEADBEEF to addr 5 (be=1111), s1 read addr 5 with READ_LATENCY=1 -> s1_readdatavalid high exactly one cycle after acceptance, s1_readdata=0xDEADBEEF. Repeat with READ_LATENCY=2 -> valid two cycles after acceptance.
- Addr 7 holds 0x11223344; s2 write 0xAABBCCDD with be=0101 -> s1 read of addr 7 returns 0x11BB33DD.
- s1 and s2 both write addr 9 in the same cycle: s1 0x000000FF be=0001, s2 0xFFFFFF00 be=1111 -> addr 9 = 0xFFFFFFFF, coll_count=1. Repeat 300 times with COLL_W=8 -> coll_count=255.
- s2 read addr 6000 (DEPTH=6000) -> s2_readdata=0 with a valid pulse, s2_oor=1 held; a subsequent s2 write to addr 6000 leaves all in-range memory unchanged.
- Four back-to-back s1 reads of addrs 0-3 with reset_req pulsed high during the second -> exactly 3 valid pulses carrying data for addrs 0, 2 and 3.
- Issue a read, assert reset in the next cycle -> no valid pulse appears. After reset, data written before reset still reads back intact.
